sd_spi_engine: RTL and testbench

//  Parametrised SPI mode-0 master for the SD card, the successor to the single-byte, single-CS shifter.

---
 rtl/sd_spi_engine.sv | 221 ++++++++++++++++++++++
 tb/tb_sd_spi_engine.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_spi_engine.sv
// sd_spi_engine
//   SPI mode-0 master for the SD card socket. Accepts a byte stream over a
//   valid/ready handshake, shifts it out MSB first with programmable slow/fast
//   clock dividers, and stores received bytes in an RX FIFO drained by the
//   68K read decoder. Back-to-back bytes run with no idle gap.
// Ports
//   clock_50_i, reset_i        system clock, async active-high reset
//   tx_data_i/valid_i/ready_o  byte stream in (tx_ready_o is combinational)
//   rx_data_o/pop_i/empty_o    RX FIFO head (combinational), pop, empty flag
//   rx_count_o, rx_ovf_o       FIFO fill level, sticky overflow flag
//   ovf_clr_i                  clears rx_ovf_o
//   high_speed_i               divider select, sampled at byte start
//   cs_sel_i, cs_assert_i      chip-select target, applied between bytes
//   lock_i                     card locked: no new transfers, all CS high
//   busy_o                     byte in flight
//   spi_clk_o/mosi_o/miso_i    SPI pins, spi_cs_n_o active-low selects
module sd_spi_engine #(
    parameter int unsigned SLOW_DIV   = 30,
    parameter int unsigned FAST_DIV   = 1,
    parameter int unsigned DIV_W      = 5,
    parameter int unsigned NUM_CS     = 2,
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic              clock_50_i,
    input  logic              reset_i,
    input  logic [7:0]        tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [7:0]        rx_data_o,
    input  logic              rx_pop_i,
    output logic              rx_empty_o,
    output logic [CNT_W-1:0]  rx_count_o,
    output logic              rx_ovf_o,
    input  logic              ovf_clr_i,
    input  logic              high_speed_i,
    input  logic [CS_W-1:0]   cs_sel_i,
    input  logic              cs_assert_i,
    input  logic              lock_i,
    output logic              busy_o,
    output logic              spi_clk_o,
    output logic              spi_mosi_o,
    input  logic              spi_miso_i,
    output logic [NUM_CS-1:0] spi_cs_n_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        sh_q, sh_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic              busy_q, busy_d;
    logic [NUM_CS-1:0] cs_n_q, cs_n_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              empty_q;
    logic              ovf_q, ovf_d;
    logic [7:0]        mem_q [FIFO_DEPTH];

    logic              tx_ready_c;
    logic              start_c;
    logic              push_c;
    logic              pop_c;
    logic              full_c;
    logic              wr_en_c;
    logic              ovf_evt_c;
    logic [NUM_CS-1:0] cs_tgt_c;

    // Chip-select pattern requested right now; at most one bit low.
    always_comb begin
        cs_tgt_c = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (cs_assert_i && !lock_i && (cs_sel_i == CS_W'(i))) begin
                cs_tgt_c[i] = 1'b0;
            end
        end
    end

    // Next-state logic. One shift register carries TX bits out of its MSB
    // and collects MISO into its LSB, so after 8 rising edges it holds the
    // received byte.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        tx_ready_c = 1'b0;
        start_c    = 1'b0;
        push_c     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_ready_c = !lock_i;
                cs_n_d     = cs_tgt_c;
                start_c    = tx_valid_i && !lock_i;
            end
            S_LOW: begin
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    sh_d    = {sh_q[6:0], spi_miso_i};
                    state_d = S_HIGH;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == div_q) begin
                    cnt_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q != 3'd7) begin
                        mosi_d  = sh_q[7];
                        bit_d   = bit_q + 3'd1;
                        state_d = S_LOW;
                    end else begin
                        // Byte boundary: store RX byte, apply deferred CS, maybe restart.
                        push_c = 1'b1;
                        cs_n_d = cs_tgt_c;
                        if (tx_valid_i && !lock_i) begin
                            tx_ready_c = 1'b1;
                            start_c    = 1'b1;
                        end else begin
                            mosi_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (start_c) begin
            sh_d    = tx_data_i;
            mosi_d  = tx_data_i[7];
            bit_d   = 3'd0;
            cnt_d   = '0;
            div_d   = high_speed_i ? DIV_W'(FAST_DIV) : DIV_W'(SLOW_DIV);
            state_d = S_LOW;
        end
        busy_d = (state_d != S_IDLE);
    end

    // FIFO bookkeeping; a simultaneous pop frees the slot for a push when full.
    always_comb begin
        pop_c     = rx_pop_i && (count_q != '0);
        full_c    = (count_q == CNT_W'(FIFO_DEPTH));
        wr_en_c   = push_c && (!full_c || pop_c);
        ovf_evt_c = push_c && full_c && !pop_c;
        wr_ptr_d  = wr_en_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(wr_en_c) - CNT_W'(pop_c);
        ovf_d     = ovf_evt_c ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clock_50_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b1;
            busy_q   <= 1'b0;
            cs_n_q   <= '1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sh_q     <= sh_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            cs_n_q   <= cs_n_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage needs no reset; only entries below count_q are ever read.
    always_ff @(posedge clock_50_i) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= sh_q;
        end
    end

    assign tx_ready_o = tx_ready_c && !reset_i;
    assign rx_data_o  = mem_q[rd_ptr_q];
    assign rx_empty_o = empty_q;
    assign rx_count_o = count_q;
    assign rx_ovf_o   = ovf_q;
    assign busy_o     = busy_q;
    assign spi_clk_o  = sclk_q;
    assign spi_mosi_o = mosi_q;
    assign spi_cs_n_o = cs_n_q;

endmodule

// File: tb/tb_sd_spi_engine.sv
// tb_sd_spi_engine
//   Bench for sd_spi_engine. A transaction-level model predicts every output
//   each cycle from byte start times and divider values; an SD card stand-in
//   answers on MISO from a table of bytes. Directed cases pin the model with
//   literal expectations, then randomized traffic runs against the model.
module tb_sd_spi_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_pop;
    logic       rx_empty;
    logic [4:0] rx_count;
    logic       rx_ovf;
    logic       ovf_clr;
    logic       hs;
    logic [0:0] cs_sel;
    logic       cs_assert;
    logic       lock;
    logic       busy;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [1:0] cs_n;

    sd_spi_engine dut (
        .clock_50_i  (clk),
        .reset_i     (rst),
        .tx_data_i   (tx_data),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready),
        .rx_data_o   (rx_data),
        .rx_pop_i    (rx_pop),
        .rx_empty_o  (rx_empty),
        .rx_count_o  (rx_count),
        .rx_ovf_o    (rx_ovf),
        .ovf_clr_i   (ovf_clr),
        .high_speed_i(hs),
        .cs_sel_i    (cs_sel),
        .cs_assert_i (cs_assert),
        .lock_i      (lock),
        .busy_o      (busy),
        .spi_clk_o   (spi_clk),
        .spi_mosi_o  (spi_mosi),
        .spi_miso_i  (spi_miso),
        .spi_cs_n_o  (cs_n)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // SD card stand-in: byte n of the session comes from card_mem[n], MSB first,
    // advancing one bit after every SPI_CLK rising edge.
    logic [7:0] card_mem [256];
    logic [7:0] card_byte;
    int         card_edges = 0;
    always @(posedge spi_clk or posedge rst) begin
        if (rst) card_edges = 0;
        else     card_edges = card_edges + 1;
    end
    always_comb begin
        card_byte = card_mem[8'(card_edges / 8)];
        spi_miso  = card_byte[3'(7 - (card_edges % 8))];
    end

    // Transaction-level model: a byte started at edge 0 with divider d spans
    // 16*(d+1) cycles; sample j lies in half-period j/(d+1), odd halves high.
    bit         m_active = 1'b0;
    int         m_j = 0;
    int         m_d = 0;
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_q [$];
    logic       m_ovf = 1'b0;
    logic [1:0] m_cs = 2'b11;
    int         m_nx = 0;
    bit         m_free, m_done, m_pop, m_full, m_oevt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_j      = 0;
            m_q.delete();
            m_ovf    = 1'b0;
            m_cs     = 2'b11;
            m_nx     = 0;
        end else begin
            m_free = !m_active;
            m_done = 1'b0;
            if (m_active) begin
                m_j = m_j + 1;
                if (m_j == 16 * (m_d + 1)) begin
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (m_free || m_done)
                m_cs = (cs_assert && !lock) ? ~(2'b01 << cs_sel) : 2'b11;
            m_pop  = rx_pop && (m_q.size() > 0);
            m_full = (m_q.size() == 16);
            m_oevt = 1'b0;
            if (m_pop) void'(m_q.pop_front());
            if (m_done) begin
                if (!m_full || m_pop) m_q.push_back(card_mem[8'(m_nx)]);
                else                  m_oevt = 1'b1;
                m_nx = m_nx + 1;
            end
            m_ovf = m_oevt ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
            if ((m_free || m_done) && tx_valid && !lock) begin
                m_active = 1'b1;
                m_j      = 0;
                m_d      = hs ? 1 : 30;
                m_data   = tx_data;
            end
        end
    end

    // Per-cycle comparison against the model.
    logic e_sclk, e_mosi, e_rdy;
    int   ph;
    always @(negedge clk) begin
        ph     = m_j / (m_d + 1);
        e_sclk = m_active && (ph % 2 == 1);
        e_mosi = m_active ? m_data[3'(7 - ph / 2)] : 1'b1;
        e_rdy  = !rst && !lock && (!m_active || (m_j == 16 * (m_d + 1) - 1 && tx_valid));
        chk("sclk", spi_clk, e_sclk);
        chk("mosi", spi_mosi, e_mosi);
        chk("busy", busy, m_active);
        chk("cs_n", cs_n, m_cs);
        chk("tx_ready", tx_ready, e_rdy);
        chk("rx_count", rx_count, m_q.size());
        chk("rx_empty", rx_empty, m_q.size() == 0);
        chk("rx_ovf", rx_ovf, m_ovf);
        if (m_q.size() > 0) chk("rx_data", rx_data, m_q[0]);
    end

    // Observation counters for the directed cases.
    int         cyc = 0;
    int         busy_cnt = 0;
    int         rise_cnt = 0;
    int         fall_cnt = 0;
    int         rise_cyc [2];
    logic [7:0] mosi_cap = 8'h00;
    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) if (busy) busy_cnt = busy_cnt + 1;
    always @(posedge spi_clk) begin
        if (rise_cnt < 2) rise_cyc[rise_cnt] = cyc;
        rise_cnt = rise_cnt + 1;
        mosi_cap = {mosi_cap[6:0], spi_mosi};
    end
    always @(negedge spi_clk) fall_cnt = fall_cnt + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clr_counts();
        busy_cnt = 0;
        rise_cnt = 0;
        fall_cnt = 0;
        mosi_cap = 8'h00;
    endtask

    task automatic send(input logic [7:0] b, input logic speed);
        logic acc;
        int   g;
        acc      = 1'b0;
        g        = 0;
        tx_data  = b;
        hs       = speed;
        tx_valid = 1'b1;
        while (!acc && g < 2000) begin
            @(negedge clk);
            acc = tx_ready;
            @(posedge clk);
            #2;
            g++;
        end
        tx_valid = 1'b0;
        chk("accept", acc, 1'b1);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy && g < 3000) begin
            step(1);
            g++;
        end
        chk("idle_wait", busy, 1'b0);
    endtask

    task automatic pop1();
        rx_pop = 1'b1;
        step(1);
        rx_pop = 1'b0;
    endtask

    logic [7:0] b3 [3];
    logic [7:0] exp_q [15];
    int         k, n, g;
    logic       acc;

    initial begin
        for (int i = 0; i < 256; i++) card_mem[i] = 8'($urandom);
        card_mem[0] = 8'h3C;
        tx_valid = 1'b0; tx_data = 8'h00; rx_pop = 1'b0; ovf_clr = 1'b0;
        hs = 1'b1; cs_sel = 1'b0; cs_assert = 1'b0; lock = 1'b0;
        step(3);
        chk("rst_sclk", spi_clk, 1'b0);
        chk("rst_mosi", spi_mosi, 1'b1);
        chk("rst_cs", cs_n, 2'b11);
        chk("rst_ready", tx_ready, 1'b0);
        chk("rst_empty", rx_empty, 1'b1);
        chk("rst_count", rx_count, 5'd0);
        rst = 1'b0;
        step(1);

        // Fast 0xA5 with card answering 0x3C.
        cs_assert = 1'b1;
        cs_sel    = 1'b0;
        step(2);
        chk("t1_cs", cs_n, 2'b10);
        clr_counts();
        send(8'hA5, 1'b1);
        wait_idle();
        chk("t1_mosi_bits", mosi_cap, 8'hA5);
        chk("t1_edges", rise_cnt, 8);
        chk("t1_time", busy_cnt, 32);
        chk("t1_rx", rx_data, 8'h3C);
        chk("t1_count", rx_count, 5'd1);
        pop1();

        // Slow 0xFF: period and byte time.
        clr_counts();
        send(8'hFF, 1'b0);
        wait_idle();
        chk("t2_period", rise_cyc[1] - rise_cyc[0], 62);
        chk("t2_time", busy_cnt, 496);
        pop1();

        // Three gapless bytes.
        for (int i = 0; i < 3; i++) b3[i] = 8'($urandom);
        clr_counts();
        tx_data = b3[0]; hs = 1'b1; tx_valid = 1'b1; n = 0; g = 0;
        while (n < 3 && g < 1000) begin
            @(negedge clk);
            acc = tx_ready;
            @(posedge clk);
            #2;
            g++;
            if (acc) begin
                n++;
                if (n < 3) tx_data = b3[n];
            end
        end
        tx_valid = 1'b0;
        wait_idle();
        chk("t3_time", busy_cnt, 96);
        chk("t3_edges", rise_cnt + fall_cnt, 48);
        chk("t3_count", rx_count, 5'd3);
        repeat (3) pop1();

        // Overflow, simultaneous push/pop when full, then pop plus clear.
        k = m_nx;
        for (int i = 0; i < 17; i++) begin
            send(8'($urandom), 1'b1);
            wait_idle();
        end
        chk("t4_count", rx_count, 5'd16);
        chk("t4_ovf", rx_ovf, 1'b1);
        send(8'($urandom), 1'b1);
        step(31);
        rx_pop = 1'b1;
        step(1);
        rx_pop = 1'b0;
        chk("t4_done", busy, 1'b0);
        chk("t4_full_pp", rx_count, 5'd16);
        rx_pop = 1'b1; ovf_clr = 1'b1;
        step(1);
        rx_pop = 1'b0; ovf_clr = 1'b0;
        chk("t4_ovf_clr", rx_ovf, 1'b0);
        chk("t4_count15", rx_count, 5'd15);
        for (int i = 0; i < 14; i++) exp_q[i] = card_mem[8'(k + 2 + i)];
        exp_q[14] = card_mem[8'(k + 17)];
        for (int i = 0; i < 15; i++) begin
            chk("t4_data", rx_data, exp_q[i]);
            pop1();
        end

        // Deferred CS change and LOCK.
        cs_sel = 1'b0; cs_assert = 1'b1;
        step(2);
        send(8'($urandom), 1'b1);
        step(5);
        cs_sel = 1'b1;
        step(10);
        chk("t5_cs_hold", cs_n, 2'b10);
        wait_idle();
        chk("t5_cs_new", cs_n, 2'b01);
        lock = 1'b1;
        step(2);
        chk("t5_lock_cs", cs_n, 2'b11);
        chk("t5_lock_rdy", tx_ready, 1'b0);
        lock = 1'b0;
        step(2);
        send(8'($urandom), 1'b1);
        step(8);
        lock = 1'b1;
        step(4);
        chk("t5_lock_mid", cs_n, 2'b01);
        wait_idle();
        chk("t5_lock_end", cs_n, 2'b11);
        lock = 1'b0;
        repeat (2) pop1();

        // Reset during bit 4.
        cs_sel = 1'b0;
        step(2);
        clr_counts();
        send(8'($urandom), 1'b1);
        g = 0;
        while (rise_cnt < 5 && g < 200) begin
            step(1);
            g++;
        end
        rst = 1'b1;
        #1;
        chk("t6_sclk", spi_clk, 1'b0);
        chk("t6_mosi", spi_mosi, 1'b1);
        chk("t6_cs", cs_n, 2'b11);
        chk("t6_busy", busy, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step(40);
        chk("t6_nopush", rx_count, 5'd0);

        // Randomized traffic: moderate popping, then starved FIFO.
        for (int phase = 0; phase < 2; phase++) begin
            for (int c = 0; c < 3000; c++) begin
                tx_valid = ($urandom_range(1, 0) == 1);
                tx_data  = 8'($urandom);
                hs       = ($urandom_range(19, 0) != 0);
                rx_pop   = (phase == 0) ? ($urandom_range(9, 0) < 4) : ($urandom_range(199, 0) == 0);
                ovf_clr  = ($urandom_range(49, 0) == 0);
                if ($urandom_range(19, 0) == 0) cs_sel = ~cs_sel;
                if ($urandom_range(29, 0) == 0) cs_assert = ~cs_assert;
                if ($urandom_range(59, 0) == 0) lock = ~lock;
                step(1);
            end
        end
        tx_valid = 1'b0; rx_pop = 1'b0; ovf_clr = 1'b0; lock = 1'b0;
        wait_idle();
        step(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
